// File: rtl/arb16_pkg.sv
// rtl/arb16_pkg.sv - shared constants and types for the 16-source round-robin arbiter
//
// Purpose: FSM state encodings, source count and select width shared by the
//          arbiter, its search sub-module and the bench.
// Ports:   none (package).
package arb16_pkg;

  localparam int NSRC = 16;
  localparam int SELW = 4;

  localparam logic [0:0] ST_IDLE = 1'b0;
  localparam logic [0:0] ST_BUSY = 1'b1;

  typedef logic [NSRC-1:0] vec_t;
  typedef logic [SELW-1:0] idx_t;

endpackage

// File: rtl/rr_pick16.sv
// rtl/rr_pick16.sv - round-robin first-set search over 16 request lines
//
// Purpose: find the first set bit of req searching start, start+1, ... mod 16.
// Ports:   req   - request vector
//          start - index where the search begins
//          found - at least one request bit is set
//          idx   - index of the first set bit in search order (0 when !found)
module rr_pick16
  import arb16_pkg::*;
(
  input  vec_t req,
  input  idx_t start,
  output logic found,
  output idx_t idx
);

  vec_t rot;
  idx_t off;

  always_comb begin
    // Rotate right by start so that bit 0 of rot is source 'start'; the
    // lowest set bit of rot is then the winner, offset from start.
    rot   = vec_t'({req, req} >> start);
    off   = '0;
    found = 1'b0;
    for (int i = NSRC - 1; i >= 0; i--) begin
      if (rot[i]) begin
        off   = idx_t'(i);
        found = 1'b1;
      end
    end
    idx = found ? idx_t'(start + off) : '0;
  end

endmodule

// File: rtl/arb16_rr.sv
// rtl/arb16_rr.sv - 16-source round-robin arbiter with hold limit and data mux
//
// Purpose: grants one of 16 requesters, rotating priority after each release,
//          preempting an owner that has held for HOLD_MAX cycles while others
//          wait, and muxes the owner's data bit onto dout.
// Ports:   clk       - clock, rising edge
//          rst_n     - asynchronous active-low reset
//          req[15:0] - request per source
//          din[15:0] - data bit per source
//          gnt[15:0] - registered one-hot grant
//          sel[3:0]  - registered index of the granted source
//          gnt_valid - gnt/sel name a valid owner
//          dout      - din[sel] while gnt_valid, else 0
module arb16_rr
  import arb16_pkg::*;
#(
  parameter int HOLD_MAX = 8
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [15:0] req,
  input  logic [15:0] din,
  output logic [15:0] gnt,
  output logic [3:0]  sel,
  output logic        gnt_valid,
  output logic        dout
);

  logic [0:0] state;
  idx_t       ptr;
  logic [7:0] hold_cnt;

  idx_t sel_inc;
  vec_t others;
  logic new_found;
  idx_t new_idx;
  logic pre_found;
  idx_t pre_idx;
  logic hold_top;

  assign sel_inc  = idx_t'(sel + 1'b1);
  assign others   = req & ~(vec_t'(1) << sel);
  assign hold_top = (hold_cnt == 8'(HOLD_MAX - 1));

  // Fresh grant from IDLE searches from the rotating pointer.
  rr_pick16 u_pick_new (
    .req   (req),
    .start (ptr),
    .found (new_found),
    .idx   (new_idx)
  );

  // Preemption looks only at the other requesters, starting after the owner.
  rr_pick16 u_pick_pre (
    .req   (others),
    .start (sel_inc),
    .found (pre_found),
    .idx   (pre_idx)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= ST_IDLE;
      gnt       <= '0;
      sel       <= '0;
      gnt_valid <= 1'b0;
      ptr       <= '0;
      hold_cnt  <= '0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (new_found) begin
            state     <= ST_BUSY;
            sel       <= new_idx;
            gnt       <= vec_t'(1) << new_idx;
            gnt_valid <= 1'b1;
            hold_cnt  <= '0;
          end
        end
        ST_BUSY: begin
          if (!req[sel]) begin
            // Release always goes through IDLE: one bubble before any regrant.
            state     <= ST_IDLE;
            gnt       <= '0;
            gnt_valid <= 1'b0;
            ptr       <= sel_inc;
            hold_cnt  <= '0;
          end else if (hold_top && pre_found) begin
            // Hand over directly, no bubble.
            sel      <= pre_idx;
            gnt      <= vec_t'(1) << pre_idx;
            ptr      <= sel_inc;
            hold_cnt <= '0;
          end else if (!hold_top) begin
            hold_cnt <= hold_cnt + 8'd1;
          end
        end
        default: begin
          state     <= ST_IDLE;
          gnt       <= '0;
          gnt_valid <= 1'b0;
        end
      endcase
    end
  end

  assign dout = gnt_valid & din[sel];

endmodule

// File: tb/tb_arb16_rr.sv
// tb/tb_arb16_rr.sv - self-checking bench for arb16_rr
module tb_arb16_rr;
  import arb16_pkg::*;

  localparam int HOLD_MAX = 8;

  logic        clk = 1'b0;
  logic        rst_n = 1'b1;
  logic [15:0] req = '0;
  logic [15:0] din = '0;
  logic [15:0] gnt;
  logic [3:0]  sel;
  logic        gnt_valid;
  logic        dout;

  int checks = 0;
  int errors = 0;
  bit chk_en = 1'b0;

  arb16_rr #(.HOLD_MAX(HOLD_MAX)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .req       (req),
    .din       (din),
    .gnt       (gnt),
    .sel       (sel),
    .gnt_valid (gnt_valid),
    .dout      (dout)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic step;
    @(posedge clk);
    #2;
  endtask

  // Behavioural model: owner index (-1 = none), rotating start, hold age.
  int m_owner = -1;
  int m_sel   = 0;
  int m_ptr   = 0;
  int m_hold  = 0;

  function automatic int first_req(input logic [15:0] r, input int start);
    for (int k = 0; k < NSRC; k++)
      if (r[(start + k) % NSRC]) return (start + k) % NSRC;
    return -1;
  endfunction

  always @(posedge clk or negedge rst_n) begin
    int n_owner, n_sel, n_ptr, n_hold;
    logic [15:0] rest;
    if (!rst_n) begin
      m_owner <= -1;
      m_sel   <= 0;
      m_ptr   <= 0;
      m_hold  <= 0;
    end else begin
      n_owner = m_owner; n_sel = m_sel; n_ptr = m_ptr; n_hold = m_hold;
      if (m_owner < 0) begin
        if (req != 0) begin
          n_owner = first_req(req, m_ptr);
          n_sel   = n_owner;
          n_hold  = 0;
        end
      end else if (!req[m_owner]) begin
        n_ptr   = (m_owner + 1) % NSRC;
        n_owner = -1;
      end else begin
        rest = req & ~(16'd1 << m_owner);
        if (m_hold == HOLD_MAX - 1 && rest != 0) begin
          n_ptr   = (m_owner + 1) % NSRC;
          n_owner = first_req(rest, n_ptr);
          n_sel   = n_owner;
          n_hold  = 0;
        end else if (m_hold < HOLD_MAX - 1) begin
          n_hold = m_hold + 1;
        end
      end
      m_owner <= n_owner;
      m_sel   <= n_sel;
      m_ptr   <= n_ptr;
      m_hold  <= n_hold;
    end
  end

  always @(negedge clk) begin
    if (chk_en) begin
      chk("m_gnt", gnt, (m_owner >= 0) ? (32'd1 << m_owner) : 32'd0);
      chk("m_valid", gnt_valid, (m_owner >= 0) ? 1 : 0);
      chk("m_sel", sel, m_sel);
      chk("m_dout", dout, (m_owner >= 0) ? din[m_owner] : 1'b0);
      chk("onehot0", $onehot0(gnt), 1);
      if (gnt_valid) chk("gnt_eq_sel", gnt, 32'd1 << sel);
    end
  end

  initial begin
    int cnt;
    bit gap;
    int ok;

    // Reset state
    #1 rst_n = 1'b0;
    din = 16'hFFFF;
    #2;
    chk("rst_gnt", gnt, 0);
    chk("rst_sel", sel, 0);
    chk("rst_valid", gnt_valid, 0);
    chk("rst_dout", dout, 0);
    step;
    step;
    rst_n = 1'b1;
    din = 16'h0001;
    chk_en = 1'b1;

    // First grant, one-cycle latency
    req = 16'h0001;
    step;
    chk("g0_gnt", gnt, 16'h0001);
    chk("g0_sel", sel, 0);
    chk("g0_valid", gnt_valid, 1);
    chk("g0_dout", dout, 1);

    // Round-robin with bubble and wrap, from a fresh pointer of 0
    rst_n = 1'b0;
    req = 16'h8001;
    step;
    rst_n = 1'b1;
    step;
    chk("rr_a_sel", sel, 0);
    chk("rr_a_valid", gnt_valid, 1);
    req = 16'h8000;
    step;
    chk("rr_bub1", gnt_valid, 0);
    step;
    chk("rr_b_gnt", gnt, 16'h8000);
    chk("rr_b_sel", sel, 15);
    req = 16'h0001;
    step;
    chk("rr_bub2", gnt_valid, 0);
    chk("rr_bub2_sel", sel, 15);
    step;
    chk("rr_wrap_sel", sel, 0);
    chk("rr_wrap_valid", gnt_valid, 1);

    // Hold limit preemption: 3 holds 8 cycles, then 5 with no gap
    req = '0;
    step;
    step;
    req = 16'h0008;
    step;
    chk("pre_own", sel, 3);
    req = 16'h0028;
    cnt = 1;
    gap = 0;
    for (int i = 0; i < 20; i++) begin
      step;
      if (!gnt_valid) gap = 1;
      if (gnt_valid && sel == 3) cnt++;
      else break;
    end
    chk("pre_hold_cycles", cnt, 8);
    chk("pre_gnt", gnt, 16'h0020);
    chk("pre_sel", sel, 5);
    chk("pre_nogap", gap, 0);

    // Preempt search wraps from owner+1: 3 owns, others 0,2,11 -> 11
    req = '0;
    step;
    step;
    req = 16'h0008;
    step;
    chk("wrap_own", sel, 3);
    req = 16'h080D;
    repeat (10) step;
    chk("wrap_pre_sel", sel, 11);

    // Lone requester keeps the grant
    req = '0;
    step;
    step;
    req = 16'h0200;
    step;
    ok = 0;
    for (int i = 0; i < 20; i++) begin
      if (gnt_valid && sel == 9) ok++;
      step;
    end
    chk("lone_hold", ok, 20);

    // Asynchronous reset mid-grant
    req = '0;
    step;
    step;
    req = 16'h0080;
    step;
    chk("ar_own", sel, 7);
    #1 rst_n = 1'b0;
    #1;
    chk("ar_gnt", gnt, 0);
    chk("ar_valid", gnt_valid, 0);
    chk("ar_sel", sel, 0);
    step;
    rst_n = 1'b1;
    req = 16'h0880;
    step;
    chk("ar_regrant", sel, 7);

    // Data mux sweep
    for (int s = 0; s < NSRC; s++) begin
      req = '0;
      step;
      step;
      req = 16'd1 << s;
      din = 16'd1 << s;
      step;
      chk("sw_sel", sel, s);
      chk("sw_dout1", dout, 1);
      din = '0;
      #1;
      chk("sw_dout0", dout, 0);
    end

    req = '0;
    step;
    step;
    chk_en = 1'b0;
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/arb16_rr.md
ARB16_RR -- requirements
Module: arb16_rr

Interface
REQ-001 The block SHALL have parameter HOLD_MAX, default 8, giving the maximum consecutive cycles one requester keeps the grant while others wait (legal range 2..255).
REQ-002 The block SHALL have port clk, input, 1, the single clock; all state updates on its rising edge.
REQ-003 The block SHALL have port rst_n, input, 1, asynchronous active-low reset.
REQ-004 The block SHALL have port req, input, 16, one request line per source; bit i is source i.
REQ-005 The block SHALL have port din, input, 16, the 16-bit shared data bus feeding the 16:1 mux; bit i is source i's data.
REQ-006 The block SHALL have port gnt, output, 16, one-hot grant, registered.
REQ-007 The block SHALL have port sel, output, 4, binary index of the granted source, registered.
REQ-008 The block SHALL have port gnt_valid, output, 1, high while gnt/sel name a valid owner.
REQ-009 The block SHALL have port dout, output, 1, the muxed data bit din[sel] when gnt_valid, else 0 (combinational).

Function
REQ-010 The block SHALL implement a two-state FSM: IDLE (no owner) and BUSY (owner = sel).
REQ-011 The block SHALL keep a 4-bit round-robin pointer ptr; search order is ptr, ptr+1, ... modulo 16, wrapping 15->0.
REQ-012 In IDLE, if req is nonzero, the block SHALL grant the first requesting source in search order on the next edge: gnt=1<<k, sel=k, gnt_valid=1, hold_cnt=0, state BUSY (one-cycle grant latency).
REQ-013 In IDLE with req==0, the block SHALL hold gnt=0, sel unchanged, gnt_valid=0.
REQ-014 In BUSY, if req[sel]==0, the block SHALL release on the next edge: gnt=0, gnt_valid=0, ptr=sel+1 (mod 16), state IDLE; sel keeps its last value.
REQ-015 Release SHALL always pass through IDLE, giving exactly one bubble cycle before any new grant, even if other requests are pending.
REQ-016 In BUSY with req[sel]==1, hold_cnt SHALL increment each cycle, saturating at HOLD_MAX-1.
REQ-017 In BUSY, if req[sel]==1, hold_cnt==HOLD_MAX-1, and any other req bit is set, the block SHALL preempt on the next edge: grant the first other requester searching from sel+1, ptr=sel+1, hold_cnt=0, state stays BUSY, no bubble.
REQ-018 If req[sel]==1 and no other request is pending, the owner SHALL retain the grant indefinitely.
REQ-019 gnt SHALL always be zero or one-hot and equal to 1<<sel whenever gnt_valid==1.
REQ-020 dout SHALL reflect din[sel] in the same cycle din changes while gnt_valid==1.

Reset
REQ-021 On rst_n low, the block SHALL immediately (asynchronously) set state=IDLE, gnt=0, sel=0, gnt_valid=0, ptr=0, hold_cnt=0; dout therefore reads 0.
REQ-022 Reset asserted mid-grant SHALL abandon the grant; after rst_n rises, the first grant SHALL start searching from source 0.

Structure
REQ-023 The FSM state encodings, the source count 16, and the select width 4 SHALL be defined in a shared package/header, arb16_pkg, used by the block and its bench.
REQ-024 The round-robin search (16-bit req, 4-bit start index -> found flag + 4-bit index) SHALL be a separate sub-module, rr_pick16, instantiated twice (new grant and preempt search) or once with a muxed start index.

Verification
REQ-025 After reset, req=16'h0001 -> one cycle later gnt=16'h0001, sel=0, gnt_valid=1; with din=16'h0001, dout=1.
REQ-026 ptr=0, req=16'h8001 from IDLE -> grant source 0. Drop req[0] -> one bubble cycle, then grant source 15. Drop req[15] with req[0] reasserted -> bubble, then source 0 (wrap).
REQ-027 HOLD_MAX=8, source 3 granted and holding, req[5] raised -> source 3 holds 8 cycles total, then gnt=16'h0020, sel=5 with no gnt_valid gap.
REQ-028 Only source 9 requests for 20 cycles -> sel=9 held for all 20 cycles, no preemption.
REQ-029 rst_n pulsed low while source 7 is granted -> gnt=0, gnt_valid=0, sel=0 without waiting for clk; after release with req=16'h0880, the grant goes to source 7.
REQ-030 Sweep sel 0..15 with din one-hot on the granted bit, then din=0 -> dout toggles 1/0 for each source; every cycle checks the one-hot and gnt==1<<sel invariants.
